// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds or subtracts two WIDTH-bit operands with one shared 4-bit
//   ripple-carry adder. The operation takes one nibble per clock, starting
//   with the least significant nibble. Subtraction is computed as A + ~B + 1.
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous, active-high reset
//     start  request, sampled in IDLE or DONE
//     sub    0: A+B+cin, 1: A-B (sampled with start)
//     a, b   WIDTH-bit operands (sampled with start)
//     cin    carry-in for add, ignored for subtract (sampled with start)
//     busy   high while nibbles are being processed (NIB cycles)
//     done   one-cycle pulse; sum/cout are valid
//     sum    result, held until the next completion or reset
//     cout   final carry (for subtract: 1 means no borrow, A >= B unsigned)
//
// ripplecarry_adder4bit
//   4-bit ripple-carry adder used as the shared nibble datapath.
//   Ports: a, b (4-bit addends), cin (carry in), sum (4-bit), cout.

module ripplecarry_adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             accept;
  logic             last;

  ripplecarry_adder4bit u_adder (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start is only honoured in IDLE and DONE; in RUN it is deliberately ignored
  // so an in-flight operation can never be disturbed or queued behind.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    last      = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      // Subtract is folded into the add: B is inverted once here and the
      // +1 enters through the initial carry.
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= {4'b0000, a_sh[WIDTH-1:4]};
      b_sh   <= {4'b0000, b_sh[WIDTH-1:4]};
      res_sh <= {nib_sum, res_sh[WIDTH-1:4]};
      carry  <= nib_cout;
      cnt    <= cnt + 1'b1;
      // Publish on the edge that enters DONE, using the final nibble directly
      // so sum/cout are already valid while done is high.
      if (last) begin
        sum  <= {nib_sum, res_sh[WIDTH-1:4]};
        cout <= nib_cout;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  logic [W:0] sb_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t tbl[9];

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        check("sum", {16'd0, sum}, {16'd0, e[W:1]});
        check("cout", {31'd0, cout}, {31'd0, e[0]});
      end
    end
  end

  // Called at the negedge of the first RUN cycle: expects NIB busy cycles,
  // then a done cycle (values checked by the scoreboard).
  task automatic expect_run(input string tag);
    for (int i = 0; i < NIB; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
    sb_q.push_back({v.s, v.c});
    @(negedge clk);
    start = 1'b0;
    // Inputs after the accepting edge must not matter.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    expect_run(tag);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {15'd0, sum, cout}, {15'd0, v.s, v.c});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h1A2B, 16'h0F0F, 1'b0, 1'b0, 16'h293A, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0};
    tbl[4] = '{16'h1234, 16'h0034, 1'b1, 1'b1, 16'h1200, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0};
    tbl[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'h0000, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-cycle clears held outputs without a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", {16'd0, sum}, 32'd0);
    check("async_rst_cout", {31'd0, cout}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start held through RUN with different operands: one result only.
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb_q.push_back({16'h0003, 1'b0});
    @(negedge clk);
    a = 16'h1111; b = 16'h1111;
    for (int i = 0; i < NIB; i++) begin
      check("hold_start_busy", {31'd0, busy}, 32'd1);
      if (i == NIB - 1) start = 1'b0;
      @(negedge clk);
    end
    check("hold_start_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_start_idle", {30'd0, busy, done}, 32'd0);
    end

    // Back-to-back: start in the DONE cycle.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; start = 1'b1;
    sb_q.push_back({16'h0030, 1'b0});
    @(negedge clk);
    start = 1'b0;
    expect_run("b2b_first");
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb_q.push_back({16'h0100, 1'b0});
    @(negedge clk);
    start = 1'b0;
    expect_run("b2b_second");
    @(negedge clk);
    check("b2b_idle", {30'd0, busy, done}, 32'd0);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midop_rst_busy", {31'd0, busy}, 32'd0);
    check("midop_rst_sum", {16'd0, sum}, 32'd0);
    check("midop_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      check("midop_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_op('{16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0}, "after_rst");

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
